// File: rtl/pc_pkg.sv
// Shared encodings and default vectors for the fetch PC sequencer.
package pc_pkg;

    localparam logic [1:0] RK_NONE   = 2'b00;
    localparam logic [1:0] RK_BRANCH = 2'b01;
    localparam logic [1:0] RK_JALR   = 2'b10;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_03FC;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target adder: branch/JAL is pc+imm, JALR is (rs1+imm) with bit 0 cleared.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      kind,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum   = rs1 + imm;
    assign target     = (kind == RK_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural fetch PC owner: sequential advance under handshake, redirects, trap entry/return.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirect targets into a trap.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int              ILEN      = 4,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_pc,
    input  logic             redir_valid,
    input  logic [1:0]       redir_kind,
    input  logic [XLEN-1:0]  redir_pc,
    input  logic [XLEN-1:0]  redir_rs1,
    input  logic [XLEN-1:0]  redir_imm,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_epc,
    input  logic             eret_req,
    output logic             flush,
    output logic [XLEN-1:0]  epc,
    output logic             misalign_fault,
    output logic [CNT_W-1:0] redir_count
);

    logic [1:0]       state_q, state_nxt;
    logic [XLEN-1:0]  pc_q, pc_nxt;
    logic [XLEN-1:0]  epc_q, epc_nxt;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  target_raw, target_taken;
    logic             target_misaligned;
    logic             in_run, take_trap, take_eret, take_redir, redir_fault, accept;

    pc_target_calc #(.XLEN(XLEN)) u_target_calc (
        .kind       (redir_kind),
        .pc         (redir_pc),
        .rs1        (redir_rs1),
        .imm        (redir_imm),
        .target     (target_raw),
        .misaligned (target_misaligned)
    );

    // Trap is honoured in RUN and TRAP; everything else only in RUN, in priority order.
    assign in_run     = (state_q == ST_RUN);
    assign take_trap  = trap_req && (state_q == ST_RUN || state_q == ST_TRAP);
    assign take_eret  = in_run && !trap_req && eret_req;
    assign take_redir = in_run && !trap_req && !eret_req && redir_valid &&
                        (redir_kind == RK_BRANCH || redir_kind == RK_JALR);
    assign accept     = take_trap || take_eret || take_redir;

`ifdef PC_MISALIGN_TRAP_EN
    assign redir_fault  = take_redir && target_misaligned;
    assign target_taken = target_raw;
`else
    assign redir_fault  = 1'b0;
    assign target_taken = target_misaligned ? {target_raw[XLEN-1:2], 2'b00} : target_raw;
`endif

    assign fetch_valid    = in_run;
    assign fetch_pc       = pc_q;
    assign epc            = epc_q;
    assign flush          = accept;
    assign misalign_fault = redir_fault;
    assign redir_count    = count_q;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        epc_nxt   = epc_q;
        if (take_trap) begin
            state_nxt = ST_TRAP;
            epc_nxt   = trap_epc;
            pc_nxt    = TRAP_VEC;
        end else if (redir_fault) begin
            state_nxt = ST_TRAP;
            epc_nxt   = redir_pc;
            pc_nxt    = TRAP_VEC;
        end else if (take_eret) begin
            pc_nxt = epc_q;
        end else if (take_redir) begin
            pc_nxt = target_taken;
        end else begin
            case (state_q)
                ST_BOOT: state_nxt = ST_RUN;
                ST_TRAP: state_nxt = ST_RUN;
                ST_RUN:  if (fetch_ready) pc_nxt = pc_q + XLEN'(ILEN);
                default: state_nxt = ST_BOOT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            epc_q   <= epc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (accept && count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic vs. a reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] TRAP_VEC  = 32'h3FC;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready, fetch_valid;
    logic [31:0] fetch_pc;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [31:0] redir_pc, redir_rs1, redir_imm;
    logic        trap_req, eret_req;
    logic [31:0] trap_epc, epc;
    logic        flush, misalign_fault;
    logic [15:0] redir_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .redir_valid    (redir_valid),
        .redir_kind     (redir_kind),
        .redir_pc       (redir_pc),
        .redir_rs1      (redir_rs1),
        .redir_imm      (redir_imm),
        .trap_req       (trap_req),
        .trap_epc       (trap_epc),
        .eret_req       (eret_req),
        .flush          (flush),
        .epc            (epc),
        .misalign_fault (misalign_fault),
        .redir_count    (redir_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = booting, 1 = fetching, 2 = in trap-entry bubble.
    int          m_mode = 0;
    logic [31:0] m_pc   = RESET_VEC;
    logic [31:0] m_epc  = 32'h0;
    logic [15:0] m_cnt  = 16'h0;

    always @(negedge clk) begin : scoreboard
        logic [31:0] tgt;
        bit t_trap, t_eret, t_redir, t_mis;
        if (!reset) begin
            m_mode = 0; m_pc = RESET_VEC; m_epc = 32'h0; m_cnt = 16'h0;
        end
        check("sb_valid", fetch_valid, (m_mode == 1));
        check("sb_pc", fetch_pc, m_pc);
        check("sb_epc", epc, m_epc);
        check("sb_count", redir_count, m_cnt);

        t_trap  = (m_mode != 0) && trap_req;
        t_eret  = (m_mode == 1) && !trap_req && eret_req;
        t_redir = (m_mode == 1) && !trap_req && !eret_req && redir_valid &&
                  (redir_kind == 2'b01 || redir_kind == 2'b10);
        tgt     = (redir_kind == 2'b01) ? redir_pc + redir_imm : (redir_rs1 + redir_imm) & ~32'h1;
        t_mis   = t_redir && MIS_EN && (tgt % 4 != 0);
        check("sb_flush", flush, t_trap || t_eret || t_redir);
        check("sb_misalign", misalign_fault, t_mis);

        if (reset) begin
            if (t_trap || t_eret || t_redir) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'h1;
            if (t_trap) begin
                m_mode = 2; m_epc = trap_epc; m_pc = TRAP_VEC;
            end else if (t_mis) begin
                m_mode = 2; m_epc = redir_pc; m_pc = TRAP_VEC;
            end else if (t_eret) begin
                m_pc = m_epc;
            end else if (t_redir) begin
                m_pc = tgt & ~32'h3;
            end else if (m_mode != 1) begin
                m_mode = 1;
            end else if (fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        redir_valid = 1'b0; redir_kind = 2'b00; redir_pc = '0; redir_rs1 = '0; redir_imm = '0;
        trap_req = 1'b0; trap_epc = '0; eret_req = 1'b0;
    endtask

    task automatic set_redir(input logic [1:0] k, input logic [31:0] p, input logic [31:0] r,
                             input logic [31:0] i);
        redir_valid = 1'b1; redir_kind = k; redir_pc = p; redir_rs1 = r; redir_imm = i;
    endtask

    initial begin
        reset = 1'b0;
        fetch_ready = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Boot cycle, then sequential fetch from the reset vector
        @(negedge clk);
        check("boot_valid", fetch_valid, 1'b0);
        check("boot_pc", fetch_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("seq_pc", fetch_pc, 32'(i * 4));
            check("seq_valid", fetch_valid, 1'b1);
        end

        // Branch back to 0x8, stall there, then redirect during the stall
        tick(); set_redir(2'b01, 32'h0, 32'h0, 32'h8);
        @(negedge clk); check("br_flush", flush, 1'b1);
        tick(); clear_inputs(); fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("stall_hold", fetch_pc, 32'h8);
            tick();
        end
        set_redir(2'b01, 32'h8, 32'h0, 32'h40);
        @(negedge clk); check("stall_redir_flush", flush, 1'b1);
        tick(); clear_inputs(); fetch_ready = 1'b1;
        @(negedge clk); check("stall_redir_pc", fetch_pc, 32'h48);

        // JALR clears bit 0
        tick(); set_redir(2'b10, 32'h48, 32'h101, 32'h4);
        @(negedge clk); check("jalr_flush", flush, 1'b1);
        tick(); clear_inputs();
        @(negedge clk);
        check("jalr_pc", fetch_pc, 32'h104);
        check("jalr_count", redir_count, 16'd3);

        // Trap beats eret and redirect in the same cycle
        tick(); trap_req = 1'b1; trap_epc = 32'h20; eret_req = 1'b1; set_redir(2'b01, 32'h0, 32'h0, 32'h80);
        @(negedge clk); check("trap_flush", flush, 1'b1);
        tick(); clear_inputs();
        @(negedge clk);
        check("trap_bubble_valid", fetch_valid, 1'b0);
        check("trap_pc", fetch_pc, 32'h3FC);
        check("trap_epc", epc, 32'h20);
        tick();
        @(negedge clk);
        check("trap_resume_valid", fetch_valid, 1'b1);
        check("trap_resume_pc", fetch_pc, 32'h3FC);
        tick();
        @(negedge clk); check("trap_wrap_pc", fetch_pc, 32'h400);
        tick(); eret_req = 1'b1;
        @(negedge clk); check("eret_flush", flush, 1'b1);
        tick(); clear_inputs();
        @(negedge clk);
        check("eret_pc", fetch_pc, 32'h20);
        check("eret_count", redir_count, 16'd5);

        // Misaligned branch target
        tick(); set_redir(2'b01, 32'h100, 32'h0, 32'h2);
        @(negedge clk); check("mis_pulse", misalign_fault, MIS_EN);
        tick(); clear_inputs();
        @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_trap_pc", fetch_pc, 32'h3FC);
        check("mis_trap_epc", epc, 32'h100);
        check("mis_pulse_end", misalign_fault, 1'b0);
`else
        check("mis_forced_pc", fetch_pc, 32'h100);
`endif

        // Randomized traffic, checked every cycle by the scoreboard
        for (int n = 0; n < 600; n++) begin
            tick();
            clear_inputs();
            fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 4) begin
                trap_req = 1'b1; trap_epc = $urandom & 32'hFFFC;
            end
            if ($urandom_range(0, 99) < 5) eret_req = 1'b1;
            if ($urandom_range(0, 99) < 20)
                set_redir(2'($urandom_range(0, 3)), $urandom & 32'hFFFC, $urandom,
                          ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFC) : $urandom);
        end
        tick(); clear_inputs(); fetch_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of a redirect
        tick(); set_redir(2'b01, 32'h40, 32'h0, 32'h40);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", fetch_valid, 1'b0);
        check("arst_pc", fetch_pc, 32'h0);
        check("arst_epc", epc, 32'h0);
        check("arst_flush", flush, 1'b0);
        check("arst_misalign", misalign_fault, 1'b0);
        check("arst_count", redir_count, 16'd0);
        repeat (2) tick();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk); check("rerun_boot_valid", fetch_valid, 1'b0);
        tick();
        @(negedge clk);
        check("rerun_valid", fetch_valid, 1'b1);
        check("rerun_pc", fetch_pc, 32'h0);
        tick();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
